ram_arbiter: RTL

- Shares the single-port synchronous data RAM between the CPU memory path (fed by the control unit's MEM micro-instructions) and a debug/loader host port.
- Arbitrates every cycle; CPU has priority; a starvation guard bounds debug latency; a debug lock gives the host exclusive ownership for program-load bursts.
- Sits between the core memory stage, the debug UART bridge and the RAM macro.

---
 rtl/ram_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous data RAM between the CPU
// memory stage and the debug/loader host port.
//
// - The CPU has priority in the OPEN state.
// - A debug lock (DBG_LOCK state) gives the host exclusive ownership while it
//   loads a program.
// - The optional starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
//   With the guard, a pending debug request loses to the CPU for at most
//   MAX_WAIT consecutive cycles. Without it, OPEN is strict CPU priority.
// - Grants are combinational. Read data returns one cycle after the grant,
//   tagged back to whichever requester issued the read.
module ram_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,

  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,

  input  logic          dbg_lock,
  output logic          dbg_owner,

  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  // Arbitration states
  localparam logic [0:0] ST_OPEN     = 1'b0;
  localparam logic [0:0] ST_DBG_LOCK = 1'b1;

  logic [0:0] r_state;
  logic [0:0] w_state_nxt;

  logic w_cpu_gnt;
  logic w_dbg_gnt;
  // Debug may win in OPEN this cycle (CPU idle, or debug has starved long enough)
  logic w_dbg_win;

  // One flag per requester acts as the read-owner tag for the returning data
  logic r_cpu_rvalid;
  logic r_dbg_rvalid;

`ifdef ARB_STARVE_GUARD_EN
  // A MAX_WAIT below 1 is treated as 1 so the counter always has a valid limit
  localparam int WAIT_LIMIT = (MAX_WAIT < 1) ? 1 : MAX_WAIT;
  localparam int WCW        = $clog2(WAIT_LIMIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(WAIT_LIMIT);

  logic [WCW-1:0] r_wait_cnt;

  assign w_dbg_win = ~cpu_req | (r_wait_cnt == WAIT_MAX);

  // Count consecutive cycles a pending debug request loses in OPEN; frozen in DBG_LOCK
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wait_cnt <= '0;
    end else if (r_state == ST_OPEN) begin
      if (w_dbg_gnt || !dbg_req) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != WAIT_MAX) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
    end
  end
`else
  // Strict CPU priority; MAX_WAIT only shapes the starvation guard
  assign w_dbg_win = ~cpu_req;

  if (MAX_WAIT < 1) begin : g_max_wait_ignored
  end
`endif

  // Grant decode: at most one winner, nothing granted while reset is held
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    w_cpu_gnt = 1'b0;
    w_dbg_gnt = 1'b0;
    if (reset) begin
      if (r_state == ST_DBG_LOCK) begin
        w_dbg_gnt = dbg_req;
      end else begin
        w_dbg_gnt = dbg_req & w_dbg_win;
        w_cpu_gnt = cpu_req & ~w_dbg_gnt;
      end
    end
  end

  assign cpu_gnt = w_cpu_gnt;
  assign dbg_gnt = w_dbg_gnt;

  // RAM port mux: follow the winner, drive zeros when idle
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (w_cpu_gnt) begin
      ram_en    = 1'b1;
      ram_we    = cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (w_dbg_gnt) begin
      ram_en    = 1'b1;
      ram_we    = dbg_we;
      ram_addr  = dbg_addr;
      ram_wdata = dbg_wdata;
    end
  end

  // Next-state logic for the OPEN / DBG_LOCK ownership FSM
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_OPEN: begin
        if (w_dbg_gnt && dbg_lock) begin
          w_state_nxt = ST_DBG_LOCK;
        end
      end
      ST_DBG_LOCK: begin
        // A request granted in the release cycle still completes normally
        if (!dbg_lock) begin
          w_state_nxt = ST_OPEN;
        end
      end
      default: w_state_nxt = ST_OPEN;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      r_state <= ST_OPEN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Read-owner tag: a read grant schedules a one-cycle rvalid for its issuer
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cpu_rvalid <= 1'b0;
      r_dbg_rvalid <= 1'b0;
    end else begin
      r_cpu_rvalid <= w_cpu_gnt & ~cpu_we;
      r_dbg_rvalid <= w_dbg_gnt & ~dbg_we;
    end
  end

  assign cpu_rvalid = r_cpu_rvalid;
  assign dbg_rvalid = r_dbg_rvalid;
  assign cpu_rdata  = r_cpu_rvalid ? ram_rdata : '0;
  assign dbg_rdata  = r_dbg_rvalid ? ram_rdata : '0;
  assign dbg_owner  = (r_state == ST_DBG_LOCK);

endmodule
